// File: rtl/dff_pkg.sv
// Shared types for the 4-bit D flip-flop stage, its elastic output buffer and the bench.
package dff_pkg;

    localparam int DFF_WIDTH  = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH) + 1;

    typedef logic [DFF_WIDTH-1:0]  dff_word_t;
    typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;

endpackage

// File: rtl/dff_q_fifo_ptr.sv
// Pointer, occupancy and flag logic for dff_q_fifo; pointers carry a wrap flag in the MSB.
module dff_q_fifo_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH)-1:0] wr_idx,
    output logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     push,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        pop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push   = in_valid & ~full;
    assign pop    = out_ready & ~empty;
    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Pointer difference modulo 2*DEPTH is exactly the occupancy, 0..DEPTH.
    assign count  = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_q_fifo.sv
// Elastic show-ahead buffer behind the D flip-flop stage; drops on full are flagged via overflow.
module dff_q_fifo
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    logic [WIDTH-1:0]         mem [DEPTH];
    logic [$clog2(DEPTH)-1:0] wr_idx;
    logic [$clog2(DEPTH)-1:0] rd_idx;
    logic                     push;

    dff_q_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .wr_idx    (wr_idx),
        .rd_idx    (rd_idx),
        .push      (push),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign in_ready  = ~full;
    assign out_valid = ~empty;

    // Storage is not reset; an empty buffer presents zero instead of stale contents.
    assign out_data  = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= in_valid & full & ~clear;
        end
    end

endmodule

// File: tb/tb_dff_q_fifo.sv
// Scoreboard bench for dff_q_fifo: directed boundary cases, a wrap stream and random traffic.
module tb_dff_q_fifo;
    import dff_pkg::*;

    localparam int DEPTH = 4;

    logic      clk = 1'b0;
    logic      reset;
    logic      clear;
    dff_word_t in_data;
    logic      in_valid;
    logic      in_ready;
    dff_word_t out_data;
    logic      out_valid;
    logic      out_ready;
    logic [2:0] count;
    logic      full;
    logic      empty;
    logic      overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the ordered list of words the buffer should hold.
    dff_word_t exp_q[$];
    logic      pend_valid = 1'b0;
    logic      pend_ovf   = 1'b0;
    logic      exp_ovf    = 1'b0;
    logic      last_accepted = 1'b0;
    dff_word_t pend_data  = '0;

    always #5 clk = ~clk;

    dff_q_fifo #(
        .WIDTH (DFF_WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic iv, input dff_word_t d, input logic ordy,
                                  input logic clr, input logic polite);
        logic full_m;
        @(posedge clk);
        #1;
        full_m = (exp_q.size() >= DEPTH);
        if (polite && full_m) iv = 1'b0;
        in_valid   = iv;
        in_data    = d;
        out_ready  = ordy;
        clear      = clr;
        pend_valid = iv && !full_m && !clr;
        pend_data  = d;
        pend_ovf   = iv && full_m && !clr;
        last_accepted = pend_valid;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " count"}, 32'(count), 32'd0);
        check_output({tag, " empty"}, 32'(empty), 32'd1);
        check_output({tag, " full"}, 32'(full), 32'd0);
        check_output({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check_output({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check_output({tag, " out_data"}, 32'(out_data), 32'd0);
        check_output({tag, " overflow"}, 32'(overflow), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        clear      = 1'b0;
        exp_q.delete();
        pend_valid = 1'b0;
        pend_ovf   = 1'b0;
        exp_ovf    = 1'b0;
        #1;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("drain empty", 32'(empty), 32'd1);
    endtask

    // Accepted words enter the model on the edge that stores them.
    always @(posedge clk) begin
        if (!reset || clear) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (pend_valid) exp_q.push_back(pend_data);
            exp_ovf = pend_ovf;
        end
        pend_valid = 1'b0;
        pend_ovf   = 1'b0;
    end

    // Monitor: compare outputs mid-cycle and retire the head word when the consumer takes it.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check_output("count", 32'(count), 32'(exp_q.size()));
            check_output("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check_output("empty", 32'(empty), 32'(exp_q.size() == 0));
            check_output("full", 32'(full), 32'(exp_q.size() == DEPTH));
            check_output("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
            check_output("overflow", 32'(overflow), 32'(exp_ovf));
            if (exp_q.size() > 0) begin
                check_output("out_data", 32'(out_data), 32'(exp_q[0]));
                if (out_ready && !clear) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        int cyc;
        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check_reset_state("power-on");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset with three words queued
        apply_stimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Ordering
        apply_stimulus(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        drain();

        // Full and overflow; 4'hF is dropped
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 4'(i + 8), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        check_output("full before drop", 32'(full), 32'd1);
        check_output("in_ready before drop", 32'(in_ready), 32'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_output("overflow pulse", 32'(overflow), 32'd1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_output("overflow single", 32'(overflow), 32'd0);
        drain();

        // Full with push and pop together: pop only
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 4'(i + 1), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_output("full+push+pop count", 32'(count), 32'd3);
        check_output("full+push+pop overflow", 32'(overflow), 32'd1);
        drain();

        // Empty with push and pop together: push only, no fall-through
        apply_stimulus(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
        check_output("no fall-through", 32'(out_valid), 32'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_output("empty+push count", 32'(count), 32'd1);
        check_output("empty+push data", 32'(out_data), 32'h9);
        drain();

        // Clear overrides a simultaneous push and pop
        apply_stimulus(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'hD, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_output("clear count", 32'(count), 32'd0);

        // Stream of 20 words honouring in_ready, consumer ready every other cycle
        idx = 0;
        cyc = 0;
        while (idx < 20 && cyc < 200) begin
            apply_stimulus(1'b1, 4'(idx), 1'(cyc), 1'b0, 1'b1);
            if (last_accepted) idx++;
            cyc++;
        end
        check_output("stream accepted", 32'(idx), 32'd20);
        drain();

        // Random traffic with occasional clears and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 31) == 0), 1'b0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
